// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and arithmetic helpers for the row convolution PE
package conv_pkg;

    localparam int PAD_ZERO = 0;
    localparam int PAD_REPL = 1;

    function automatic int acc_width(input int data_w, input int coef_w, input int kernel_w);
        return data_w + coef_w + 1 + $clog2(kernel_w);
    endfunction

    // Clamp a signed sum into the unsigned pixel range [0, 2^data_w-1].
    function automatic logic [31:0] saturate(input logic signed [31:0] v, input int data_w);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< data_w) - 32'sd1;
        if (v < 0)
            return '0;
        else if (v > max_v)
            return max_v;
        else
            return v;
    endfunction

endpackage

// File: rtl/row_conv_mac.sv
// rtl/row_conv_mac.sv - three-stage product / adder-tree / normalise pipeline
module row_conv_mac
    import conv_pkg::*;
#(
    parameter int                          DATA_W     = 8,
    parameter int                          KERNEL_W   = 7,
    parameter int                          COEF_W     = 5,
    parameter logic [KERNEL_W*COEF_W-1:0]  WEIGHTS    = '0,
    parameter int                          NORM_SHIFT = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [KERNEL_W*DATA_W-1:0]   i_win,
    input  logic                         i_launch,
    input  logic                         i_eor,
    input  logic                         i_adv,
    output logic                         o_vld,
    output logic                         o_eor,
    output logic [DATA_W-1:0]            o_data
);

    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, KERNEL_W);

    logic signed [PROD_W-1:0] prod_c [KERNEL_W];
    logic signed [PROD_W-1:0] prod_q [KERNEL_W];
    logic signed [PROD_W-1:0] px_ext;
    logic signed [PROD_W-1:0] cf_ext;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_sh;
    logic                     vld1, eor1, vld2, eor2;

    // Pixels enter as unsigned, so they are zero-extended before the signed multiply.
    always_comb begin
        px_ext = '0;
        cf_ext = '0;
        for (int j = 0; j < KERNEL_W; j++) begin
            px_ext    = PROD_W'({1'b0, i_win[j*DATA_W +: DATA_W]});
            cf_ext    = PROD_W'($signed(WEIGHTS[j*COEF_W +: COEF_W]));
            prod_c[j] = px_ext * cf_ext;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int j = 0; j < KERNEL_W; j++)
            sum_c = sum_c + ACC_W'(prod_q[j]);
    end

    assign acc_sh = acc_q >>> NORM_SHIFT;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld1   <= 1'b0;
            eor1   <= 1'b0;
            vld2   <= 1'b0;
            eor2   <= 1'b0;
            acc_q  <= '0;
            o_vld  <= 1'b0;
            o_eor  <= 1'b0;
            o_data <= '0;
            for (int j = 0; j < KERNEL_W; j++)
                prod_q[j] <= '0;
        end else if (i_adv) begin
            vld1   <= i_launch;
            eor1   <= i_launch && i_eor;
            for (int j = 0; j < KERNEL_W; j++)
                prod_q[j] <= prod_c[j];
            vld2   <= vld1;
            eor2   <= eor1;
            acc_q  <= sum_c;
            o_vld  <= vld2;
            o_eor  <= eor2;
            o_data <= DATA_W'(saturate(32'(acc_sh), DATA_W));
        end
    end

endmodule

// File: rtl/row_conv_pe.sv
// rtl/row_conv_pe.sv - horizontal "same"-size convolution PE with zero/replicate row padding
module row_conv_pe
    import conv_pkg::*;
#(
    parameter int                          DATA_W     = 8,
    parameter int                          KERNEL_W   = 7,
    parameter int                          COEF_W     = 5,
    parameter logic [KERNEL_W*COEF_W-1:0]  WEIGHTS    = {5'sd7, -5'sd6, 5'sd5, -5'sd4, 5'sd3, -5'sd2, 5'sd1},
    parameter int                          NORM_SHIFT = 5,
    parameter int                          PAD_MODE   = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_vld,
    input  logic               i_eor,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_rdy,
    output logic               o_vld,
    output logic               o_eor,
    output logic [DATA_W-1:0]  o_data,
    input  logic               i_rdy
);

    localparam int R  = (KERNEL_W - 1) / 2;
    localparam int CW = $clog2(R + 2);
    localparam int FW = $clog2(R + 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(R + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(R - 1);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]                 state;
    logic [CW-1:0]              cnt, cnt_nxt;
    logic [FW-1:0]              fcnt;
    logic [DATA_W-1:0]          sr [KERNEL_W];
    logic [DATA_W-1:0]          pad_reg, pad_px, pad_first, push_px;
    logic [KERNEL_W*DATA_W-1:0] win;
    logic                       win_vld, win_eor;
    logic                       adv, accept, first, push, launch, flush_last;

    always_comb begin
        adv        = !o_vld || i_rdy;
        o_rdy      = adv && (state != ST_FLUSH);
        accept     = o_rdy && i_vld;
        first      = accept && (state == ST_FILL) && (cnt == '0);
        push       = accept || (adv && (state == ST_FLUSH));
        pad_px     = (PAD_MODE == PAD_REPL) ? pad_reg : '0;
        pad_first  = (PAD_MODE == PAD_REPL) ? i_data : '0;
        push_px    = accept ? i_data : pad_px;
        cnt_nxt    = first ? CW'(1) : ((cnt == CNT_FULL) ? cnt : cnt + 1'b1);
        // A window is complete once R pixels have arrived past its centre.
        launch     = push && (cnt_nxt == CNT_FULL);
        flush_last = (state == ST_FLUSH) && (fcnt == FLUSH_LAST);
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < KERNEL_W; i++)
            win[i*DATA_W +: DATA_W] = sr[i];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_FILL;
            cnt     <= '0;
            fcnt    <= '0;
            pad_reg <= '0;
            win_vld <= 1'b0;
            win_eor <= 1'b0;
            for (int i = 0; i < KERNEL_W; i++)
                sr[i] <= '0;
        end else if (adv) begin
            win_vld <= launch;
            win_eor <= push && flush_last;
            if (push) begin
                for (int i = 1; i < KERNEL_W; i++)
                    sr[i] <= first ? pad_first : sr[i-1];
                sr[0] <= push_px;
                cnt   <= cnt_nxt;
            end
            case (state)
                ST_FILL: begin
                    if (accept && i_eor) begin
                        state   <= ST_FLUSH;
                        pad_reg <= i_data;
                        fcnt    <= '0;
                    end else if (accept && (cnt_nxt == CNT_FULL)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && i_eor) begin
                        state   <= ST_FLUSH;
                        pad_reg <= i_data;
                        fcnt    <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_last) begin
                        state <= ST_FILL;
                        cnt   <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    row_conv_mac #(
        .DATA_W     (DATA_W),
        .KERNEL_W   (KERNEL_W),
        .COEF_W     (COEF_W),
        .WEIGHTS    (WEIGHTS),
        .NORM_SHIFT (NORM_SHIFT)
    ) u_mac (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_win    (win),
        .i_launch (win_vld),
        .i_eor    (win_eor),
        .i_adv    (adv),
        .o_vld    (o_vld),
        .o_eor    (o_eor),
        .o_data   (o_data)
    );

endmodule

// File: tb/tb_row_conv_pe.sv
// tb/tb_row_conv_pe.sv - randomized bench for row_conv_pe against a direct convolution model
module tb_row_conv_pe;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       vld      = 1'b0;
    logic       eor      = 1'b0;
    logic       rdy      = 1'b1;
    logic       rdy_rand = 1'b0;
    logic [7:0] data     = '0;

    wire [3:0]      ov, oe, ordy;
    wire [3:0][7:0] od;

    int n_checks = 0;
    int n_fail   = 0;
    int n_extra  = 0;
    int rdy_low  = 0;
    int wts [4][7];
    int shf [4];
    int pmode [4];
    int rowbuf [64];
    int imp [7] = '{7, 0, 23, 0, 39, 0, 55};
    int b2b_len [3] = '{5, 1, 9};
    int neor;

    logic [35:0] exp_q [$];
    logic [35:0] log_q [$];
    logic [35:0] ent;
    logic [35:0] held = '0;
    logic        stall_prev = 1'b0;

    always #5 clk = ~clk;

    // Four configurations share one stream; control timing is identical, only data differs.
    row_conv_pe u_zero (
        .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_eor(eor), .i_data(data), .o_rdy(ordy[0]),
        .o_vld(ov[0]), .o_eor(oe[0]), .o_data(od[0]), .i_rdy(rdy));
    row_conv_pe #(.PAD_MODE(1)) u_repl (
        .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_eor(eor), .i_data(data), .o_rdy(ordy[1]),
        .o_vld(ov[1]), .o_eor(oe[1]), .o_data(od[1]), .i_rdy(rdy));
    row_conv_pe #(.WEIGHTS({7{5'd15}}), .NORM_SHIFT(0)) u_satp (
        .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_eor(eor), .i_data(data), .o_rdy(ordy[2]),
        .o_vld(ov[2]), .o_eor(oe[2]), .o_data(od[2]), .i_rdy(rdy));
    row_conv_pe #(.WEIGHTS({7{5'h1f}}), .NORM_SHIFT(0)) u_satn (
        .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_eor(eor), .i_data(data), .o_rdy(ordy[3]),
        .o_vld(ov[3]), .o_eor(oe[3]), .o_data(od[3]), .i_rdy(rdy));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [35:0] cur_out();
        logic [35:0] r;
        for (int c = 0; c < 4; c++)
            r[c*9 +: 9] = {oe[c], od[c]};
        return r;
    endfunction

    // out[k] = clamp((sum_j W_j * x[k+3-j]) >>> shift), padded per configuration.
    function automatic logic [35:0] ref_entry(input int k, input int len);
        logic [35:0] e;
        int acc, idx, px;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            acc = 0;
            for (int j = 0; j < 7; j++) begin
                idx = k + 3 - j;
                if (idx < 0)
                    px = (pmode[c] != 0) ? rowbuf[0] : 0;
                else if (idx >= len)
                    px = (pmode[c] != 0) ? rowbuf[len-1] : 0;
                else
                    px = rowbuf[idx];
                acc += wts[c][j] * px;
            end
            acc = acc >>> shf[c];
            if (acc < 0) acc = 0;
            if (acc > 255) acc = 255;
            e[c*9 +: 9] = {(k == len - 1), 8'(acc)};
        end
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        logic [35:0] cur, ex;
        cur = cur_out();
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            check("rdy_sync", 64'(ordy), 64'({4{ordy[0]}}));
            if (stall_prev) begin
                check("hold_vld", ov[0], 1);
                check("hold_out", cur, held);
            end
            if (ov[0] && rdy) begin
                log_q.push_back(cur);
                if (exp_q.size() == 0) begin
                    n_extra++;
                end else begin
                    ex = exp_q.pop_front();
                    for (int c = 0; c < 4; c++)
                        check($sformatf("out_c%0d", c), cur[c*9 +: 9], ex[c*9 +: 9]);
                end
            end
            if ((!ov[0] || rdy) && !ordy[0])
                rdy_low++;
            stall_prev = ov[0] && !rdy;
            held = cur;
        end
    end

    task automatic wait_accept();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = ordy[0];
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", done, 1);
    endtask

    task automatic send_row(input int len, input bit gaps);
        for (int k = 0; k < len; k++)
            exp_q.push_back(ref_entry(k, len));
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    vld = 1'b0;
                    eor = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            vld  = 1'b1;
            data = 8'(rowbuf[i]);
            eor  = (i == len - 1);
            wait_accept();
        end
    endtask

    task automatic end_stream();
        vld = 1'b0;
        eor = 1'b0;
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++)
            rowbuf[i] = $urandom_range(0, 255);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_missing"}, exp_q.size(), 0);
        check({tag, "_extra"}, n_extra, 0);
        exp_q.delete();
        n_extra = 0;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            shf[c]   = (c < 2) ? 5 : 0;
            pmode[c] = (c == 1) ? 1 : 0;
            for (int j = 0; j < 7; j++)
                wts[c][j] = (c < 2) ? ((j % 2 == 0) ? j + 1 : -(j + 1)) : ((c == 2) ? 15 : -1);
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld", ov, 0);
        check("rst_eor", oe, 0);
        check("rst_data", od, 0);
        check("rst_rdy", ordy, 4'hf);
        @(posedge clk);
        #1;

        // Impulse under zero padding
        for (int i = 0; i < 7; i++) rowbuf[i] = 0;
        rowbuf[3] = 255;
        log_q.delete();
        send_row(7, 1'b0);
        end_stream();
        drain("impulse");
        check("imp_n", log_q.size(), 7);
        for (int i = 0; i < 7 && i < log_q.size(); i++) begin
            ent = log_q[i];
            check("imp_px", ent[8:0], 64'(imp[i] + ((i == 6) ? 256 : 0)));
        end

        // Single-pixel row, replicate padding
        rowbuf[0] = 100;
        log_q.delete();
        send_row(1, 1'b0);
        end_stream();
        drain("len1");
        check("len1_n", log_q.size(), 1);
        if (log_q.size() > 0) begin
            ent = log_q[0];
            check("len1_repl", ent[17:9], 256 + 12);
        end

        // Back-to-back rows with valid held high
        log_q.delete();
        rdy_low = 0;
        for (int r = 0; r < 3; r++) begin
            fill_random(b2b_len[r]);
            send_row(b2b_len[r], 1'b0);
        end
        end_stream();
        drain("b2b");
        neor = 0;
        foreach (log_q[i]) begin
            ent = log_q[i];
            neor += int'(ent[8]);
        end
        check("b2b_n", log_q.size(), 15);
        check("b2b_eor", neor, 3);
        check("b2b_rdy_low", rdy_low, 9);

        // Reset in the middle of a flush
        fill_random(6);
        send_row(6, 1'b0);
        end_stream();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_vld", ov, 0);
        check("mid_rst_eor", oe, 0);
        check("mid_rst_data", od, 0);
        check("mid_rst_rdy", ordy, 4'hf);
        exp_q.delete();
        n_extra = 0;
        log_q.delete();
        @(posedge clk);
        #1;
        fill_random(4);
        send_row(4, 1'b0);
        end_stream();
        drain("post_rst");
        check("post_rst_n", log_q.size(), 4);

        // Backpressure and random rows
        rdy_rand = 1'b1;
        fill_random(32);
        send_row(32, 1'b0);
        end_stream();
        drain("bp");
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 12);
            fill_random(len);
            send_row(len, 1'b1);
        end
        end_stream();
        drain("rand");

        // Saturation at both ends
        log_q.delete();
        for (int i = 0; i < 10; i++) rowbuf[i] = 255;
        send_row(10, 1'b0);
        end_stream();
        drain("sat");
        check("sat_n", log_q.size(), 10);
        foreach (log_q[i]) begin
            ent = log_q[i];
            check("sat_pos", ent[25:18], 255);
            check("sat_neg", ent[34:27], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
